// File: rtl/tx_frac_bit_timer.sv
// Fractional-period TX bit timer: phase accumulator strobe generator with byte bit counter.
// Optional stuff-bit insertion is compiled in when TX_TIMER_STUFF_EN is defined.
module tx_frac_bit_timer #(
  parameter int ACC_W     = 8,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable_timer,
  input  logic                 disable_timer,
  input  logic                 clear_timer,
  input  logic [ACC_W-1:0]     period_num,
  input  logic [ACC_W-1:0]     period_den,
  input  logic [BIT_CNT_W-1:0] bits_per_byte,
`ifdef TX_TIMER_STUFF_EN
  input  logic                 stuff_req,
  output logic                 stuff_strobe,
`endif
  output logic                 shift_strobe,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 byte_complete,
  output logic                 active
);

  logic [ACC_W-1:0]     acc;
  logic [ACC_W:0]       sum;
  logic [ACC_W-1:0]     acc_wrap;
  logic                 hit;
  logic                 advance;
  logic                 stuff_now;
  logic [BIT_CNT_W-1:0] count_next;

  assign advance = enable_timer & ~disable_timer & ~clear_timer;

  // The remainder is always below 2**ACC_W, so modulo arithmetic gives it exactly.
  assign acc_wrap = acc + period_den - period_num;

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, period_den};
    hit = (sum >= {1'b0, period_num});
    if (bits_per_byte == '0)
      count_next = '0;
    else if (bit_count >= bits_per_byte)
      count_next = BIT_CNT_W'(1);
    else
      count_next = bit_count + 1'b1;
  end

`ifdef TX_TIMER_STUFF_EN
  logic stuff_pending;

  // A request seen on this very edge already applies to the period ending here.
  assign stuff_now = stuff_pending | (shift_strobe & stuff_req);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stuff_pending <= 1'b0;
      stuff_strobe  <= 1'b0;
    end else begin
      stuff_strobe <= 1'b0;
      if (clear_timer) begin
        stuff_pending <= 1'b0;
      end else if (advance && hit) begin
        stuff_strobe  <= stuff_now;
        stuff_pending <= 1'b0;
      end else if (shift_strobe && stuff_req) begin
        stuff_pending <= 1'b1;
      end
    end
  end
`else
  assign stuff_now = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc           <= '0;
      bit_count     <= '0;
      shift_strobe  <= 1'b0;
      byte_complete <= 1'b0;
      active        <= 1'b0;
    end else begin
      active        <= advance;
      shift_strobe  <= 1'b0;
      byte_complete <= 1'b0;
      if (clear_timer) begin
        acc       <= '0;
        bit_count <= '0;
      end else if (advance) begin
        if (hit) begin
          acc <= acc_wrap;
          if (!stuff_now) begin
            shift_strobe  <= 1'b1;
            bit_count     <= count_next;
            byte_complete <= (bits_per_byte != '0) && (count_next == bits_per_byte);
          end
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule
